// File: rtl/bytemask_data_mem.sv
// Byte-masked data memory for the MIPS M stage: read-modify-write lane merge, counted clear sweep, write-event trace record.
// Optional drop counter output drop_cnt is built when DM_DROP_COUNT_EN is defined.
`timescale 1ns/1ps

module bytemask_data_mem #(
    parameter int DEPTH_WORDS = 4096,
    parameter int READ_LAT    = 0,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        busy,
    output logic        addr_err,
    output logic        wr_evt_valid,
    output logic [31:0] wr_evt_pc,
    output logic [31:0] wr_evt_addr,
`ifdef DM_DROP_COUNT_EN
    output logic [15:0] drop_cnt,
`endif
    output logic [31:0] wr_evt_data
);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  clr_idx_q;
    logic              addr_err_q;
    logic              evt_valid_q;
    logic [31:0]       evt_pc_q;
    logic [31:0]       evt_addr_q;
    logic [31:0]       evt_data_q;

    logic [31:0]       mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              idle;
    logic              wr_req;
    logic              commit;
    logic [31:0]       cur_word;
    logic [31:0]       merged_d;
    logic [31:0]       rd_word;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [31:0]       mem_wdata;

    assign idx      = m_data_addr[IDX_W+1:2];
    assign in_range = ({2'b00, m_data_addr[31:2]} < 32'(DEPTH_WORDS));
    assign idle     = (state_q == ST_IDLE);
    assign wr_req   = |m_data_byteen;
    assign commit   = idle && !reset && wr_req && in_range;
    assign cur_word = mem_q[idx];
    assign rd_word  = (idle && in_range) ? cur_word : 32'h0;

    always_comb begin
        // NOTE: default assignment first keeps combinational blocks free of inferred latches.
        merged_d = cur_word;
        for (int k = 0; k < 4; k++) begin
            if (m_data_byteen[k]) merged_d[8*k +: 8] = m_data_wdata[8*k +: 8];
        end
    end

    // Single write port shared by the clear sweep and committed stores.
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = idx;
        mem_wdata = merged_d;
        if (!reset) begin
            if (state_q == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_widx  = clr_idx_q;
                mem_wdata = 32'h0;
            end else if (commit) begin
                mem_we = 1'b1;
            end
        end
    end

    // NOTE: the array has no reset branch; the clear sweep zeroes it one word per cycle.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_widx] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q     <= ST_CLEAR;
            clr_idx_q   <= '0;
            addr_err_q  <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_pc_q    <= 32'h0;
            evt_addr_q  <= 32'h0;
            evt_data_q  <= 32'h0;
        end else begin
            if (state_q == ST_CLEAR) begin
                clr_idx_q <= clr_idx_q + IDX_W'(1);
                if (clr_idx_q == IDX_W'(DEPTH_WORDS - 1)) state_q <= ST_IDLE;
            end
            addr_err_q  <= idle && wr_req && !in_range;
            evt_valid_q <= commit;
            if (commit) begin
                evt_pc_q   <= m_inst_addr;
                evt_addr_q <= m_data_addr & 32'hFFFF_FFFC;
                evt_data_q <= merged_d;
            end
        end
    end

    generate
        if (READ_LAT == 1) begin : g_rd_reg
            logic [31:0] rdata_q;
            // A commit always targets the word being read, so write-first returns the merged word.
            always_ff @(posedge clk) begin
                if (reset) rdata_q <= 32'h0;
                else       rdata_q <= commit ? merged_d : rd_word;
            end
            assign m_data_rdata = rdata_q;
        end else begin : g_rd_comb
            assign m_data_rdata = rd_word;
        end
    endgenerate

`ifdef DM_DROP_COUNT_EN
    logic [15:0] drop_cnt_q;
    logic [15:0] drop_cnt_d;
    logic        dropped;

    assign dropped = wr_req && (!idle || !in_range);

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (dropped && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) drop_cnt_q <= 16'h0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign busy         = reset || (state_q == ST_CLEAR);
    assign addr_err     = addr_err_q;
    assign wr_evt_valid = evt_valid_q;
    assign wr_evt_pc    = evt_pc_q;
    assign wr_evt_addr  = evt_addr_q;
    assign wr_evt_data  = evt_data_q;

endmodule
